// File: rtl/p4_router_egress_demux_ctrl_if.sv
// AXI-Stream bundle used by the egress demux for its ingress and per-port egress.
// master drives tvalid/tdata/tkeep/tstrb/tlast/tid/tdest/tuser; slave drives tready.
interface p4_router_egress_demux_ctrl_if #(
  parameter int DATA_BYTES = 64,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_BYTES*8-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic [DATA_BYTES-1:0]   tstrb;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb,
    output tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb,
    input  tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/p4_router_egress_demux_ctrl.sv
// Packet-atomic egress demux: egr_bus (tuser=port on SOP) -> egr_ports[], with gating,
// drop of bad targets, per-port pkt/byte counters, drop counter and drop pulse.
module p4_router_egress_demux_ctrl #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_BYTES = 64,
  parameter int CNT_WIDTH  = 32,
  parameter int SEL_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4
) (
  input  logic clk_ifc,
  input  logic areset_ifc,
  p4_router_egress_demux_ctrl_if.slave  egr_bus,
  p4_router_egress_demux_ctrl_if.master egr_ports [NUM_PORTS],
  input  logic [NUM_PORTS-1:0] egr_ports_enable,
  input  logic [NUM_PORTS-1:0] egr_cnts_clear,
  output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] egr_pkt_cnts,
  output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] egr_byte_cnts,
  output logic [CNT_WIDTH-1:0] egr_drop_cnt,
  output logic egr_drop
);
  localparam int DW   = DATA_BYTES * 8;
  localparam int PCW  = $clog2(DATA_BYTES + 1);
  localparam int SPAN = 1 << SEL_WIDTH;
  localparam int AW   = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d, load_sel;
  logic rdy, load, drop_now;

  logic [NUM_PORTS-1:0] p_ready, o_valid, o_last, loadable;
  logic [DW-1:0]         o_data [NUM_PORTS];
  logic [DATA_BYTES-1:0] o_keep [NUM_PORTS];
  logic [DATA_BYTES-1:0] o_strb [NUM_PORTS];
  logic [ID_WIDTH-1:0]   o_id   [NUM_PORTS];
  logic [DEST_WIDTH-1:0] o_dest [NUM_PORTS];

  logic [SPAN-1:0] en_pad, ld_pad;
  logic in_range, tgt_ok;

  function automatic logic [PCW-1:0] popcnt(
    input logic [DATA_BYTES-1:0] k
  );
    popcnt = '0;
    for (int i = 0; i < DATA_BYTES; i++)
      popcnt = popcnt + PCW'(k[i]);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input logic [PCW-1:0] b
  );
    logic [AW-1:0] s;
    s = AW'(a) + AW'(b);
    sat_add = (s > AW'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(s);
  endfunction

  // A register can take a new beat while its old one leaves this cycle.
  assign loadable = ~o_valid | p_ready;
  // Padding to the full tuser range keeps out-of-range indices harmless.
  assign en_pad   = SPAN'(egr_ports_enable);
  assign ld_pad   = SPAN'(loadable);
  assign in_range = 32'(egr_bus.tuser) < 32'(NUM_PORTS);
  assign tgt_ok   = in_range & en_pad[egr_bus.tuser];

  assign egr_bus.tready = rdy & ~areset_ifc;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rdy      = 1'b0;
    load     = 1'b0;
    load_sel = sel_q;
    drop_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tgt_ok) begin
          rdy = ld_pad[egr_bus.tuser];
          if (egr_bus.tvalid && rdy) begin
            load     = 1'b1;
            load_sel = egr_bus.tuser;
            sel_d    = egr_bus.tuser;
            if (!egr_bus.tlast) state_d = FWD;
          end
        end else begin
          rdy = 1'b1;
          if (egr_bus.tvalid) begin
            drop_now = 1'b1;
            if (!egr_bus.tlast) state_d = DROP;
          end
        end
      end
      FWD: begin
        rdy = ld_pad[sel_q];
        if (egr_bus.tvalid && rdy) begin
          load = 1'b1;
          if (egr_bus.tlast) state_d = IDLE;
        end
      end
      DROP: begin
        rdy = 1'b1;
        if (egr_bus.tvalid && egr_bus.tlast)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_ifc or posedge areset_ifc) begin
    if (areset_ifc) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_ff @(posedge clk_ifc or posedge areset_ifc) begin
    if (areset_ifc) begin
      o_valid <= '0;
      o_last  <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        o_data[p] <= '0;
        o_keep[p] <= '0;
        o_strb[p] <= '0;
        o_id[p]   <= '0;
        o_dest[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (load && load_sel == SEL_WIDTH'(p)) begin
          o_valid[p] <= 1'b1;
          o_last[p]  <= egr_bus.tlast;
          o_data[p]  <= egr_bus.tdata;
          o_keep[p]  <= egr_bus.tkeep;
          o_strb[p]  <= egr_bus.tstrb;
          o_id[p]    <= egr_bus.tid;
          o_dest[p]  <= egr_bus.tdest;
        end else if (p_ready[p]) begin
          o_valid[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_ifc or posedge areset_ifc) begin
    if (areset_ifc) begin
      egr_pkt_cnts  <= '0;
      egr_byte_cnts <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (egr_cnts_clear[p]) begin
          egr_pkt_cnts[p]  <= '0;
          egr_byte_cnts[p] <= '0;
        end else if (o_valid[p] && p_ready[p]) begin
          egr_byte_cnts[p] <= sat_add(egr_byte_cnts[p], popcnt(o_keep[p]));
          if (o_last[p])
            egr_pkt_cnts[p] <= sat_add(egr_pkt_cnts[p], PCW'(1));
        end
      end
    end
  end

  always_ff @(posedge clk_ifc or posedge areset_ifc) begin
    if (areset_ifc) begin
      egr_drop     <= 1'b0;
      egr_drop_cnt <= '0;
    end else begin
      egr_drop <= drop_now;
      if (egr_cnts_clear[0])
        egr_drop_cnt <= '0;
      else if (drop_now)
        egr_drop_cnt <= sat_add(egr_drop_cnt, PCW'(1));
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign p_ready[g]          = egr_ports[g].tready;
    assign egr_ports[g].tvalid = o_valid[g];
    assign egr_ports[g].tdata  = o_data[g];
    assign egr_ports[g].tkeep  = o_keep[g];
    assign egr_ports[g].tstrb  = o_strb[g];
    assign egr_ports[g].tlast  = o_last[g];
    assign egr_ports[g].tid    = o_id[g];
    assign egr_ports[g].tdest  = o_dest[g];
    assign egr_ports[g].tuser  = '0;
  end
endmodule

// File: tb/tb_p4_router_egress_demux_ctrl.sv
// Bench for p4_router_egress_demux_ctrl: 3 ports, 4-byte bus, 5-bit counters.
// Vector table, directed corner sequences and random traffic vs a packet-level model.
module tb_p4_router_egress_demux_ctrl;
  localparam int NP   = 3;
  localparam int DB   = 4;
  localparam int CW   = 5;
  localparam int SW   = 2;
  localparam int DW   = DB * 8;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [DB-1:0] keep;
    logic [DB-1:0] strb;
    logic          last;
    logic [3:0]    id;
    logic [3:0]    dest;
  } beat_t;

  typedef struct {
    int            u;
    logic [NP-1:0] en;
    logic [DB-1:0] keep;
    int            port;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0] en, clr, prdy, pv;
  beat_t pb [NP];
  logic [NP-1:0][CW-1:0] pkt_cnts, byte_cnts;
  logic [CW-1:0] drop_cnt;
  logic drop;
  logic rnd_rdy = 1'b0;

  int checks = 0;
  int failures = 0;

  beat_t expq [NP][$];
  int mpkt [NP];
  int mbyte [NP];
  int mdrop;
  int mcur;
  logic exp_drop;

  always #5 clk = ~clk;

  p4_router_egress_demux_ctrl_if #(.DATA_BYTES(DB), .USER_WIDTH(SW)) bus ();
  p4_router_egress_demux_ctrl_if #(.DATA_BYTES(DB), .USER_WIDTH(SW)) ports [NP] ();

  p4_router_egress_demux_ctrl #(
    .NUM_PORTS(NP), .DATA_BYTES(DB), .CNT_WIDTH(CW)
  ) dut (
    .clk_ifc(clk),
    .areset_ifc(rst),
    .egr_bus(bus),
    .egr_ports(ports),
    .egr_ports_enable(en),
    .egr_cnts_clear(clr),
    .egr_pkt_cnts(pkt_cnts),
    .egr_byte_cnts(byte_cnts),
    .egr_drop_cnt(drop_cnt),
    .egr_drop(drop)
  );

  for (genvar g = 0; g < NP; g++) begin : g_tap
    assign ports[g].tready = prdy[g];
    assign pv[g] = ports[g].tvalid;
    assign pb[g] = {ports[g].tdata, ports[g].tkeep, ports[g].tstrb,
                    ports[g].tlast, ports[g].tid, ports[g].tdest};
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      expq[p].delete();
      mpkt[p] = 0;
      mbyte[p] = 0;
    end
    mdrop = 0;
    mcur = -1;
    exp_drop = 1'b0;
  endtask

  // Packet-level reference: a packet's fate is decided once, at its first beat.
  always @(posedge clk) begin : model
    beat_t b;
    beat_t e;
    logic dn;
    if (!rst) begin
      dn = 1'b0;
      if (bus.tvalid && bus.tready) begin
        b = {bus.tdata, bus.tkeep, bus.tstrb, bus.tlast, bus.tid, bus.tdest};
        if (mcur < 0) begin
          if (int'(bus.tuser) < NP && en[bus.tuser]) mcur = int'(bus.tuser);
          else begin
            mcur = NP;
            dn = 1'b1;
          end
        end
        if (mcur < NP) expq[mcur].push_back(b);
        if (bus.tlast) mcur = -1;
      end
      for (int p = 0; p < NP; p++) begin
        if (pv[p] && prdy[p]) begin
          chk("beat_queued", 64'(expq[p].size() > 0), 64'd1);
          if (expq[p].size() > 0) begin
            e = expq[p].pop_front();
            chk("beat_data", 64'(pb[p]), 64'(e));
            mbyte[p] = sat(mbyte[p] + $countones(e.keep));
            if (e.last) mpkt[p] = sat(mpkt[p] + 1);
          end
        end
        if (clr[p]) begin
          mpkt[p] = 0;
          mbyte[p] = 0;
        end
      end
      if (dn) mdrop = sat(mdrop + 1);
      if (clr[0]) mdrop = 0;
      exp_drop = dn;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        chk("pkt_cnt", 64'(pkt_cnts[p]), 64'(mpkt[p]));
        chk("byte_cnt", 64'(byte_cnts[p]), 64'(mbyte[p]));
      end
      chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
      chk("drop_pulse", 64'(drop), 64'(exp_drop));
    end
  end

  always @(posedge clk) begin
    #2;
    if (rnd_rdy) prdy = NP'($urandom);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int u, input logic [DB-1:0] k, input logic l);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    bus.tvalid = 1'b1;
    bus.tuser = SW'(u);
    bus.tdata = $urandom;
    bus.tkeep = k;
    bus.tstrb = k;
    bus.tlast = l;
    bus.tid = 4'($urandom);
    bus.tdest = 4'($urandom);
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.tready;
      cyc();
      n++;
    end
    bus.tvalid = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_pkt(input int u, input int len, input logic [DB-1:0] lk);
    for (int i = 0; i < len; i++)
      send(u, (i == len - 1) ? lk : 4'hF, i == len - 1);
  endtask

  task automatic clear_all();
    clr = '1;
    cyc();
    clr = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tv [7];
    int pulses;
    int u;
    int len;

    tv[0] = '{u: 0, en: 3'b111, keep: 4'hF, port: 0};
    tv[1] = '{u: 1, en: 3'b111, keep: 4'h3, port: 1};
    tv[2] = '{u: 2, en: 3'b111, keep: 4'h1, port: 2};
    tv[3] = '{u: 2, en: 3'b011, keep: 4'hF, port: -1};
    tv[4] = '{u: 3, en: 3'b111, keep: 4'hF, port: -1};
    tv[5] = '{u: 1, en: 3'b101, keep: 4'hF, port: -1};
    tv[6] = '{u: 0, en: 3'b001, keep: 4'h0, port: 0};

    bus.tvalid = 1'b0;
    bus.tuser = '0;
    bus.tdata = '0;
    bus.tkeep = '0;
    bus.tstrb = '0;
    bus.tlast = 1'b0;
    bus.tid = '0;
    bus.tdest = '0;
    en = '1;
    clr = '0;
    prdy = '1;
    model_reset();

    #2;
    chk("rst_tready", 64'(bus.tready), 64'd0);
    chk("rst_tvalid", 64'(pv), 64'd0);
    chk("rst_pkt", 64'(pkt_cnts), 64'd0);
    chk("rst_byte", 64'(byte_cnts), 64'd0);
    chk("rst_dropcnt", 64'(drop_cnt), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    cyc();
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      en = tv[i].en;
      send(tv[i].u, tv[i].keep, 1'b1);
      for (int p = 0; p < NP; p++)
        chk("tv_valid", 64'(pv[p]), 64'(tv[i].port == p));
      chk("tv_drop", 64'(drop), 64'(tv[i].port < 0));
      cyc();
    end

    en = '1;
    clear_all();
    send_pkt(2, 3, 4'b0111);
    cyc();
    cyc();
    chk("route_pkt2", 64'(pkt_cnts[2]), 64'd1);
    chk("route_byte2", 64'(byte_cnts[2]), 64'd11);
    chk("route_pkt0", 64'(pkt_cnts[0]), 64'd0);
    chk("route_pkt1", 64'(pkt_cnts[1]), 64'd0);

    prdy = '0;
    send(2, 4'hF, 1'b1);
    send(1, 4'hF, 1'b0);
    fork
      begin
        send(1, 4'hF, 1'b0);
        send(1, 4'hF, 1'b0);
        send(1, 4'h3, 1'b1);
      end
      begin
        @(negedge clk);
        chk("bp_stall", 64'(bus.tready), 64'd0);
        chk("bp_hold2", 64'(pv[2]), 64'd1);
        cyc();
        prdy[2] = 1'b1;
        repeat (2) @(negedge clk);
        chk("bp_drain2", 64'(pv[2]), 64'd0);
        chk("bp_stall", 64'(bus.tready), 64'd0);
        repeat (3) begin
          @(negedge clk);
          chk("bp_stall", 64'(bus.tready), 64'd0);
          chk("bp_hold1", 64'(pv[1]), 64'd1);
        end
        cyc();
        prdy = '1;
      end
    join
    cyc();
    cyc();

    clear_all();
    en = 3'b011;
    pulses = 0;
    fork
      send_pkt(2, 3, 4'hF);
      repeat (6) begin
        @(negedge clk);
        pulses += int'(drop);
        if (bus.tvalid) chk("gate_tready", 64'(bus.tready), 64'd1);
        chk("gate_quiet", 64'(pv), 64'd0);
      end
    join
    chk("gate_pulses", 64'(pulses), 64'd1);
    chk("gate_dropcnt", 64'(drop_cnt), 64'd1);

    en = '1;
    clear_all();
    send(2, 4'hF, 1'b0);
    en = 3'b011;
    send(2, 4'hF, 1'b0);
    send(2, 4'h1, 1'b1);
    cyc();
    cyc();
    chk("midgate_pkt", 64'(pkt_cnts[2]), 64'd1);
    chk("midgate_byte", 64'(byte_cnts[2]), 64'd9);

    en = '1;
    clear_all();
    send(3, 4'hF, 1'b1);
    send(0, 4'h7, 1'b1);
    cyc();
    cyc();
    chk("oor_dropcnt", 64'(drop_cnt), 64'd1);
    chk("oor_pkt0", 64'(pkt_cnts[0]), 64'd1);
    chk("oor_byte0", 64'(byte_cnts[0]), 64'd3);

    clear_all();
    repeat (33) send(0, 4'hF, 1'b1);
    cyc();
    cyc();
    chk("sat_pkt0", 64'(pkt_cnts[0]), 64'(CMAX));
    chk("sat_byte0", 64'(byte_cnts[0]), 64'(CMAX));
    send(0, 4'hF, 1'b1);
    clr[0] = 1'b1;
    cyc();
    clr = '0;
    chk("clrwin_pkt0", 64'(pkt_cnts[0]), 64'd0);
    chk("clrwin_byte0", 64'(byte_cnts[0]), 64'd0);

    send(2, 4'hF, 1'b1);
    send(1, 4'hF, 1'b0);
    send(1, 4'hF, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_tvalid", 64'(pv), 64'd0);
    chk("arst_pkt", 64'(pkt_cnts), 64'd0);
    chk("arst_byte", 64'(byte_cnts), 64'd0);
    chk("arst_tready", 64'(bus.tready), 64'd0);
    cyc();
    rst = 1'b0;
    send_pkt(0, 2, 4'hF);
    cyc();
    cyc();
    chk("arst_pkt0", 64'(pkt_cnts[0]), 64'd1);
    chk("arst_byte0", 64'(byte_cnts[0]), 64'd8);
    chk("arst_pkt1", 64'(pkt_cnts[1]), 64'd0);

    rnd_rdy = 1'b1;
    for (int n = 0; n < 250; n++) begin
      u = $urandom_range(0, 3);
      len = $urandom_range(1, 4);
      en = NP'($urandom);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 4) == 0) en = NP'($urandom);
        clr = ($urandom_range(0, 15) == 0) ? NP'($urandom) : '0;
        send((b == 0) ? u : $urandom_range(0, 3),
             (b == len - 1) ? 4'($urandom) : 4'hF, b == len - 1);
        clr = '0;
      end
      if ($urandom_range(0, 3) == 0) cyc();
    end
    rnd_rdy = 1'b0;
    prdy = '1;
    repeat (10) cyc();
    for (int p = 0; p < NP; p++)
      chk("drain_empty", 64'(expq[p].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
